prog_fetch_unit: RTL and testbench
==================================

# prog_fetch_unit

Single-clock, parametrised program store and fetch sequencer placed between the switch/data-entry path and the processor. It replaces the earlier split-clock counter-plus-memory pairing: the operator loads words sequentially into an internal RAM, then the unit streams them to the processor in address order over a valid/ready handshake. It supports optional wrap-around and early termination on the processor's `Done`.

## Interface
- `DATA_W`, 16, instruction/data word width
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `WRAP_EN`, 0, 1 = restart at address 0 after the last loaded word; 0 = stop in HALT

Ports:
- `Clock`  in  1  single system clock, rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Wr`  in  1  load strobe, one word per cycle while high
- `WrData`  in  DATA_W  word to load
- `Clear`  in  1  empty the store (IDLE/HALT only)
- `Run`  in  1  start streaming
- `Ready`  in  1  processor accepts `DataOut` this cycle
- `Done`  in  1  processor finished; abort streaming
- `DataOut`  out  DATA_W  word presented to processor
- `Valid`  out  1  `DataOut` valid
- `Addr`  out  ADDR_W  address of the word on `DataOut`
- `Count`  out  ADDR_W+1  number of words loaded (0..DEPTH)
- `Full`  out  1  `Count == DEPTH`
- `Busy`  out  1  state is FETCH or PRESENT
- `Halted`  out  1  state is HALT

## Operation
- States: IDLE, FETCH, PRESENT, HALT.
- IDLE:
  - `Wr=1` and `!Full`: `mem[Count] <= WrData`, `Count++`.
  - `Wr` while `Full` is ignored; `Count` does not change.
  - `Clear=1`: `Count <= 0`; wins over a simultaneous `Wr`.
  - `Run=1` and `Count>0`: read pointer set to 0, go to FETCH.
  - `Run` with `Count==0` is ignored.
  - `Run` and `Wr` in the same cycle: `Run` wins, no write.
- FETCH: RAM read of `mem[rptr]` issued; next state PRESENT.
- PRESENT:
  - `Valid=1`, `DataOut`/`Addr` held stable until accepted.
  - `Ready=1` accepts the word. If `rptr == Count-1`: with `WRAP_EN=1`, `rptr <= 0` and go to FETCH; with `WRAP_EN=0`, go to HALT. Otherwise `rptr++` and go to FETCH.
- `Done=1` in FETCH or PRESENT returns to IDLE next cycle. It takes priority over `Ready`; the word is not counted as accepted.
- HALT:
  - `Run` restarts from address 0 (go to FETCH).
  - `Clear` empties the store and goes to IDLE.
  - `Wr` is ignored.
- `Wr`, `WrData`, `Clear` are ignored in FETCH and PRESENT.
- Wrap arithmetic is modulo `Count`, never modulo `DEPTH`.
- `Count` is ADDR_W+1 bits so that DEPTH is representable.

## Timing
- Reset values: state IDLE, `DataOut=0`, `Valid=0`, `Addr=0`, `Count=0`, `Full=0`, `Busy=0`, `Halted=0`. RAM contents are undefined.
- All outputs are registered.
- `Run` sampled at edge N: `Valid=1` from cycle N+2.
- Accept (`Valid&Ready`) at edge M: `Valid=0` at M+1 (FETCH); next word valid at M+2. Throughput is one word per 2 cycles.
- Write latency is 1 cycle: a word written at edge N is readable by a FETCH starting at N+1.
- `Done` at edge N: `Valid=0`, `Busy=0` at N+1.
- `Full` and `Count` update on the same edge as the write.
- `Reset` mid-stream returns all outputs to their reset values at the next edge and discards loaded words (`Count=0`).

## Structure
- Shared package `pfu_pkg`: state enum (`S_IDLE`, `S_FETCH`, `S_PRESENT`, `S_HALT`) and default width constants (`PFU_DATA_W=16`, `PFU_ADDR_W=5`).
- Sub-module `prog_ram`:
  - single-port synchronous RAM, parametrised `DATA_W`/`ADDR_W`
  - write enable, registered read data
  - no reset on contents
- The top level holds the FSM, `Count`, the read pointer and the output registers.

## Test plan
- Load 3 words (0x1111, 0x2222, 0x3333) with `Ready` held 1, then `Run`:
  - `Count=3`
  - `Valid` at Run+2
  - `DataOut` sequence 0x1111/0x2222/0x3333 at addresses 0,1,2
  - then `Halted=1`, `Valid=0` (`WRAP_EN=0`)
- Same load with `WRAP_EN=1` and `Ready=1` for 8 accepts: the `Addr` sequence is 0,1,2,0,1,2,0,1.
- Load 32 words (ADDR_W=5):
  - `Full=1`, `Count=32`
  - a 33rd `Wr` of 0xDEAD leaves `Count=32`
  - streaming shows no 0xDEAD
- `Ready` low for 5 cycles in PRESENT: `DataOut`/`Addr` stay stable, then one accept advances `Addr` by exactly 1.
- `Done` asserted in PRESENT with `Ready=1`: IDLE next cycle, `Valid=0`; a new `Run` restarts at `Addr=0`.
- Corner cases:
  - `Run` with `Count=0` is ignored.
  - `Clear`+`Wr` in the same cycle gives `Count=0`.
  - `Reset` mid-stream: all outputs return to their reset values next edge.

Source files
------------

// File: rtl/pfu_pkg.sv
// Shared types and default widths for the program fetch unit.
package pfu_pkg;

    localparam int PFU_DATA_W = 16;
    localparam int PFU_ADDR_W = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_HALT    = 2'd3
    } pfu_state_e;

endpackage

// File: rtl/prog_fetch_unit_if.sv
// Load/stream bus between the data-entry path, the fetch unit and the processor.
interface prog_fetch_unit_if #(
    parameter int DATA_W = pfu_pkg::PFU_DATA_W,
    parameter int ADDR_W = pfu_pkg::PFU_ADDR_W
);
    logic              Wr;
    logic [DATA_W-1:0] WrData;
    logic              Clear;
    logic              Run;
    logic              Ready;
    logic              Done;
    logic [DATA_W-1:0] DataOut;
    logic              Valid;
    logic [ADDR_W-1:0] Addr;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Busy;
    logic              Halted;

    modport master (
        output Wr, WrData, Clear, Run, Ready, Done,
        input  DataOut, Valid, Addr, Count, Full, Busy, Halted
    );

    modport slave (
        input  Wr, WrData, Clear, Run, Ready, Done,
        output DataOut, Valid, Addr, Count, Full, Busy, Halted
    );
endinterface

// File: rtl/prog_ram.sv
// Single-port synchronous program RAM with registered read data.
module prog_ram #(
    parameter int DATA_W = pfu_pkg::PFU_DATA_W,
    parameter int ADDR_W = pfu_pkg::PFU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Contents are never reset; only the read register is, so DataOut starts at 0.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/prog_fetch_unit.sv
// Program store and fetch sequencer: sequential load into RAM, then stream to the processor.
import pfu_pkg::*;

module prog_fetch_unit #(
    parameter int DATA_W  = PFU_DATA_W,
    parameter int ADDR_W  = PFU_ADDR_W,
    parameter int WRAP_EN = 0
) (
    input  logic               Clock,
    input  logic               Reset,
    prog_fetch_unit_if.slave   bus
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    pfu_state_e        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              last_word;

    // Wrap is modulo the loaded count, not the RAM depth.
    assign last_word = ({1'b0, rptr_q} == (count_q - 1'b1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rptr_d   = rptr_q;
        addr_d   = addr_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = rptr_q;

        case (state_q)
            S_IDLE: begin
                ram_addr = count_q[ADDR_W-1:0];
                if (bus.Run && (count_q != '0)) begin
                    rptr_d  = '0;
                    state_d = S_FETCH;
                end else if (bus.Clear) begin
                    count_d = '0;
                end else if (bus.Wr && !full_q) begin
                    ram_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.Done) begin
                    state_d = S_IDLE;
                end else begin
                    ram_re  = 1'b1;
                    addr_d  = rptr_q;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.Done) begin
                    state_d = S_IDLE;
                end else if (bus.Ready) begin
                    if (last_word) begin
                        if (WRAP_EN != 0) begin
                            rptr_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_HALT;
                        end
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (bus.Clear) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (bus.Run) begin
                    rptr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        valid_d  = (state_d == S_PRESENT);
        busy_d   = (state_d == S_FETCH) || (state_d == S_PRESENT);
        halted_d = (state_d == S_HALT);
        full_d   = (count_d == DEPTH_C);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rptr_q   <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rptr_q   <= rptr_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    prog_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clock),
        .rst   (Reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.WrData),
        .rdata (ram_rdata)
    );

    assign bus.DataOut = ram_rdata;
    assign bus.Valid   = valid_q;
    assign bus.Addr    = addr_q;
    assign bus.Count   = count_q;
    assign bus.Full    = full_q;
    assign bus.Busy    = busy_q;
    assign bus.Halted  = halted_q;
endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit: one non-wrapping and one wrapping instance share stimulus.
module tb_prog_fetch_unit;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr = 1'b0;
    logic          clear = 1'b0;
    logic          run = 1'b0;
    logic          ready = 1'b0;
    logic          done = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    prog_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.Wr = wr;      assign if1.Wr = wr;
    assign if0.WrData = wr_data; assign if1.WrData = wr_data;
    assign if0.Clear = clear; assign if1.Clear = clear;
    assign if0.Run = run;    assign if1.Run = run;
    assign if0.Ready = ready; assign if1.Ready = ready;
    assign if0.Done = done;  assign if1.Done = done;

    prog_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .WRAP_EN(0)) u0 (
        .Clock (clk), .Reset (rst), .bus (if0)
    );
    prog_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .WRAP_EN(1)) u1 (
        .Clock (clk), .Reset (rst), .bus (if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; clear = 1'b0; run = 1'b0; ready = 1'b0; done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_words(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            wr = 1'b1;
            wr_data = DW'(base + i * step);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (if0.DataOut !== 16'h0) begin $display("FAIL reset_dataout got %h exp 0000", if0.DataOut); n_err++; end n_cmp++;
        if (if0.Valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", if0.Valid); n_err++; end n_cmp++;
        if (if0.Addr !== 5'd0) begin $display("FAIL reset_addr got %0d exp 0", if0.Addr); n_err++; end n_cmp++;
        if (if0.Count !== 6'd0) begin $display("FAIL reset_count got %0d exp 0", if0.Count); n_err++; end n_cmp++;
        if ({if0.Full, if0.Busy, if0.Halted} !== 3'b000) begin
            $display("FAIL reset_flags got %b exp 000", {if0.Full, if0.Busy, if0.Halted}); n_err++;
        end n_cmp++;
    endtask

    task automatic test_stream_nowrap();
        do_reset();
        load_words(3, 'h1111, 'h1111);
        if (if0.Count !== 6'd3) begin $display("FAIL nowrap_count got %0d exp 3", if0.Count); n_err++; end n_cmp++;
        if (if0.Full !== 1'b0) begin $display("FAIL nowrap_full got %b exp 0", if0.Full); n_err++; end n_cmp++;
        ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        if ({if0.Valid, if0.Busy} !== 2'b01) begin
            $display("FAIL nowrap_fetch valid/busy got %b exp 01", {if0.Valid, if0.Busy}); n_err++;
        end n_cmp++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (if0.Valid !== 1'b1) begin $display("FAIL nowrap_valid[%0d] got %b exp 1", k, if0.Valid); n_err++; end n_cmp++;
            if (if0.DataOut !== DW'((k + 1) * 'h1111)) begin
                $display("FAIL nowrap_data[%0d] got %h exp %h", k, if0.DataOut, DW'((k + 1) * 'h1111)); n_err++;
            end n_cmp++;
            if (if0.Addr !== AW'(k)) begin $display("FAIL nowrap_addr[%0d] got %0d exp %0d", k, if0.Addr, k); n_err++; end n_cmp++;
            tick();
            if (k < 2) begin
                if ({if0.Valid, if0.Busy} !== 2'b01) begin
                    $display("FAIL nowrap_gap[%0d] valid/busy got %b exp 01", k, {if0.Valid, if0.Busy}); n_err++;
                end n_cmp++;
            end else begin
                if ({if0.Halted, if0.Valid, if0.Busy} !== 3'b100) begin
                    $display("FAIL nowrap_halt halted/valid/busy got %b exp 100", {if0.Halted, if0.Valid, if0.Busy}); n_err++;
                end n_cmp++;
            end
        end
        ready = 1'b0;
        wr = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        wr = 1'b0;
        if (if0.Count !== 6'd3) begin $display("FAIL halt_wr_ignored count got %0d exp 3", if0.Count); n_err++; end n_cmp++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        if ({if0.Count, if0.Halted} !== {6'd0, 1'b0}) begin
            $display("FAIL halt_clear count/halted got %0d/%b exp 0/0", if0.Count, if0.Halted); n_err++;
        end n_cmp++;
    endtask

    task automatic test_wrap();
        int acc;
        do_reset();
        load_words(3, 'h1111, 'h1111);
        ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
            tick();
            if (if1.Valid === 1'b1) begin
                if (if1.Addr !== AW'(acc % 3)) begin
                    $display("FAIL wrap_addr[%0d] got %0d exp %0d", acc, if1.Addr, acc % 3); n_err++;
                end n_cmp++;
                if (if1.DataOut !== DW'((acc % 3 + 1) * 'h1111)) begin
                    $display("FAIL wrap_data[%0d] got %h exp %h", acc, if1.DataOut, DW'((acc % 3 + 1) * 'h1111)); n_err++;
                end n_cmp++;
                acc++;
            end
        end
        if (acc != 8) begin $display("FAIL wrap_accepts got %0d exp 8", acc); n_err++; end n_cmp++;
        if (if0.Halted !== 1'b1) begin $display("FAIL nowrap_peer_halted got %b exp 1", if0.Halted); n_err++; end n_cmp++;
        ready = 1'b0;
    endtask

    task automatic test_full();
        int acc;
        do_reset();
        load_words(31, 'h0100, 1);
        if ({if0.Full, if0.Count} !== {1'b0, 6'd31}) begin
            $display("FAIL full_31 full/count got %b/%0d exp 0/31", if0.Full, if0.Count); n_err++;
        end n_cmp++;
        load_words(1, 'h011F, 1);
        if ({if0.Full, if0.Count} !== {1'b1, 6'd32}) begin
            $display("FAIL full_32 full/count got %b/%0d exp 1/32", if0.Full, if0.Count); n_err++;
        end n_cmp++;
        load_words(1, 'hDEAD, 0);
        if ({if0.Full, if0.Count} !== {1'b1, 6'd32}) begin
            $display("FAIL full_33rd full/count got %b/%0d exp 1/32", if0.Full, if0.Count); n_err++;
        end n_cmp++;
        ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 100 && acc < 32; cyc++) begin
            tick();
            if (if0.Valid === 1'b1) begin
                if ({if0.Addr, if0.DataOut} !== {AW'(acc), DW'('h0100 + acc)}) begin
                    $display("FAIL full_stream[%0d] addr/data got %0d/%h exp %0d/%h",
                             acc, if0.Addr, if0.DataOut, acc, DW'('h0100 + acc)); n_err++;
                end n_cmp++;
                acc++;
            end
        end
        if (acc != 32) begin $display("FAIL full_accepts got %0d exp 32", acc); n_err++; end n_cmp++;
        tick();
        if (if0.Halted !== 1'b1) begin $display("FAIL full_halted got %b exp 1", if0.Halted); n_err++; end n_cmp++;
        ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        load_words(3, 'h1111, 'h1111);
        ready = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if ({if0.Valid, if0.Addr, if0.DataOut} !== {1'b1, 5'd0, 16'h1111}) begin
                $display("FAIL stall_hold[%0d] valid/addr/data got %b/%0d/%h exp 1/0/1111",
                         i, if0.Valid, if0.Addr, if0.DataOut); n_err++;
            end n_cmp++;
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        if (if0.Valid !== 1'b0) begin $display("FAIL stall_accept valid got %b exp 0", if0.Valid); n_err++; end n_cmp++;
        tick();
        if ({if0.Valid, if0.Addr, if0.DataOut} !== {1'b1, 5'd1, 16'h2222}) begin
            $display("FAIL stall_advance valid/addr/data got %b/%0d/%h exp 1/1/2222",
                     if0.Valid, if0.Addr, if0.DataOut); n_err++;
        end n_cmp++;
    endtask

    task automatic test_done();
        ready = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        ready = 1'b0;
        if ({if0.Valid, if0.Busy, if0.Halted} !== 3'b000) begin
            $display("FAIL done_idle valid/busy/halted got %b exp 000", {if0.Valid, if0.Busy, if0.Halted}); n_err++;
        end n_cmp++;
        if (if0.Count !== 6'd3) begin $display("FAIL done_count got %0d exp 3", if0.Count); n_err++; end n_cmp++;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        if ({if0.Valid, if0.Addr, if0.DataOut} !== {1'b1, 5'd0, 16'h1111}) begin
            $display("FAIL done_restart valid/addr/data got %b/%0d/%h exp 1/0/1111",
                     if0.Valid, if0.Addr, if0.DataOut); n_err++;
        end n_cmp++;
    endtask

    task automatic test_corners();
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        if ({if0.Busy, if0.Valid, if0.Count} !== {1'b0, 1'b0, 6'd0}) begin
            $display("FAIL run_empty busy/valid/count got %b/%b/%0d exp 0/0/0", if0.Busy, if0.Valid, if0.Count); n_err++;
        end n_cmp++;
        load_words(2, 'h4444, 1);
        clear = 1'b1;
        wr = 1'b1;
        wr_data = 16'h5555;
        tick();
        clear = 1'b0;
        wr = 1'b0;
        if (if0.Count !== 6'd0) begin $display("FAIL clear_wr count got %0d exp 0", if0.Count); n_err++; end n_cmp++;
        load_words(1, 'h7777, 0);
        run = 1'b1;
        wr = 1'b1;
        wr_data = 16'h8888;
        tick();
        run = 1'b0;
        wr = 1'b0;
        if ({if0.Count, if0.Busy} !== {6'd1, 1'b1}) begin
            $display("FAIL run_wr count/busy got %0d/%b exp 1/1", if0.Count, if0.Busy); n_err++;
        end n_cmp++;
        tick();
        if ({if0.Valid, if0.DataOut} !== {1'b1, 16'h7777}) begin
            $display("FAIL run_wr_data valid/data got %b/%h exp 1/7777", if0.Valid, if0.DataOut); n_err++;
        end n_cmp++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({if0.DataOut, if0.Valid, if0.Addr, if0.Count, if0.Full, if0.Busy, if0.Halted} !== '0) begin
            $display("FAIL reset_mid data/valid/count/busy got %h/%b/%0d/%b exp 0000/0/0/0",
                     if0.DataOut, if0.Valid, if0.Count, if0.Busy); n_err++;
        end n_cmp++;
    endtask

    initial begin
        test_reset();
        test_stream_nowrap();
        test_wrap();
        test_full();
        test_stall();
        test_done();
        test_corners();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
